// File: rtl/cordic_angle_pkg.sv
// Shared constants, state encoding and region codes for the CORDIC angle reducer.
package cordic_angle_pkg;

  localparam int unsigned ANGLE_W = 32;

  // Q3.29 multiples of pi/2
  localparam logic [ANGLE_W-1:0] PI_HALF       = 32'h3243F6A9;
  localparam logic [ANGLE_W-1:0] PI            = 32'h6487ED51;
  localparam logic [ANGLE_W-1:0] THREE_PI_HALF = 32'h96CBE3FA;
  localparam logic [ANGLE_W-1:0] TWO_PI        = 32'hC90FDAA2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRAP,
    ST_CLASS,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    REGION_Q1 = 2'b00,
    REGION_Q2 = 2'b01,
    REGION_Q3 = 2'b10,
    REGION_Q4 = 2'b11
  } region_e;

endpackage

// File: rtl/cordic_angle_reducer_if.sv
// Requester and CORDIC-core handshake bundle for the angle reducer.
interface cordic_angle_reducer_if #(
  parameter int unsigned ANGLE_W = cordic_angle_pkg::ANGLE_W
);
  logic               start;
  logic [ANGLE_W-1:0] angle_in;
  logic               operation_in;
  logic               ack_result;
  logic               ready_CORDIC;
  logic               busy;
  logic               done;
  logic               beg_FSM_CORDIC;
  logic               ACK_FSM_CORDIC;
  logic               operation;
  logic [1:0]         shift_region_flag;
  logic [ANGLE_W-1:0] angle_red;
  logic               sign_neg;

  modport master (
    output start, angle_in, operation_in, ack_result, ready_CORDIC,
    input  busy, done, beg_FSM_CORDIC, ACK_FSM_CORDIC, operation,
           shift_region_flag, angle_red, sign_neg
  );

  modport slave (
    input  start, angle_in, operation_in, ack_result, ready_CORDIC,
    output busy, done, beg_FSM_CORDIC, ACK_FSM_CORDIC, operation,
           shift_region_flag, angle_red, sign_neg
  );
endinterface

// File: rtl/cordic_region_classify.sv
// Folds a wrapped angle in [0, 2pi) onto [0, pi/2] and derives the result sign.
module cordic_region_classify
  import cordic_angle_pkg::*;
(
  input  logic [ANGLE_W-1:0] a_r,
  input  logic               operation,
  output region_e            flag_c,
  output logic [ANGLE_W-1:0] phi_c,
  output logic               sign_neg_c
);

  // Comparison order guarantees every subtraction is non-negative
  always_comb begin
    flag_c = REGION_Q1;
    phi_c  = a_r;
    if (a_r < PI_HALF) begin
      flag_c = REGION_Q1;
      phi_c  = a_r;
    end else if (a_r < PI) begin
      flag_c = REGION_Q2;
      phi_c  = a_r - PI_HALF;
    end else if (a_r < THREE_PI_HALF) begin
      flag_c = REGION_Q3;
      phi_c  = THREE_PI_HALF - a_r;
    end else begin
      flag_c = REGION_Q4;
      phi_c  = TWO_PI - a_r;
    end
    // sine is negative in Q3/Q4, cosine in Q2/Q3
    if (operation) sign_neg_c = (flag_c == REGION_Q3) || (flag_c == REGION_Q4);
    else           sign_neg_c = (flag_c == REGION_Q2) || (flag_c == REGION_Q3);
  end

endmodule

// File: rtl/cordic_angle_reducer.sv
// Reduces an angle modulo 2pi to the first quadrant and hands it to the CORDIC core.
module cordic_angle_reducer
  import cordic_angle_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  cordic_angle_reducer_if.slave bus
);

  state_e             state_q, state_d;
  logic [ANGLE_W-1:0] a_r_q, a_r_d;
  logic [ANGLE_W-1:0] angle_red_q, angle_red_d;
  region_e            flag_q, flag_d;
  logic               sign_neg_q, sign_neg_d;
  logic               operation_q, operation_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               beg_q, beg_d;

  region_e            flag_c;
  logic [ANGLE_W-1:0] phi_c;
  logic               sign_neg_c;

  cordic_region_classify u_classify (
    .a_r        (a_r_q),
    .operation  (operation_q),
    .flag_c     (flag_c),
    .phi_c      (phi_c),
    .sign_neg_c (sign_neg_c)
  );

  always_comb begin
    state_d     = state_q;
    a_r_d       = a_r_q;
    angle_red_d = angle_red_q;
    flag_d      = flag_q;
    sign_neg_d  = sign_neg_q;
    operation_d = operation_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_r_d       = bus.angle_in;
          operation_d = bus.operation_in;
          state_d     = ST_WRAP;
        end
      end
      ST_WRAP: begin
        // 8 - 2pi < 2pi, so a single conditional subtract completes the modulo
        if (a_r_q >= TWO_PI) a_r_d = a_r_q - TWO_PI;
        state_d = ST_CLASS;
      end
      ST_CLASS: begin
        angle_red_d = phi_c;
        flag_d      = flag_c;
        sign_neg_d  = sign_neg_c;
        state_d     = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (bus.ready_CORDIC) state_d = ST_DONE;
      ST_DONE:   if (bus.ack_result)   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Status flags are registered copies of the upcoming state
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    beg_d  = (state_d == ST_LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      a_r_q       <= '0;
      angle_red_q <= '0;
      flag_q      <= REGION_Q1;
      sign_neg_q  <= 1'b0;
      operation_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      beg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_r_q       <= a_r_d;
      angle_red_q <= angle_red_d;
      flag_q      <= flag_d;
      sign_neg_q  <= sign_neg_d;
      operation_q <= operation_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      beg_q       <= beg_d;
    end
  end

  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.beg_FSM_CORDIC    = beg_q;
  assign bus.ACK_FSM_CORDIC    = (state_q == ST_DONE) && bus.ack_result;
  assign bus.operation         = operation_q;
  assign bus.shift_region_flag = flag_q;
  assign bus.angle_red         = angle_red_q;
  assign bus.sign_neg          = sign_neg_q;

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// Self-checking bench: table of angles with expected reduction, plus handshake and reset sequences.
module tb_cordic_angle_reducer;

  typedef struct {
    logic [31:0] angle;
    logic        op;
    logic [1:0]  flag;
    logic [31:0] phi;
    logic        sign;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[11];
  vec_t sb[$];

  cordic_angle_reducer_if bus ();

  cordic_angle_reducer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_busy"},      32'(bus.busy), 32'd0);
    chk({pfx, "_done"},      32'(bus.done), 32'd0);
    chk({pfx, "_beg"},       32'(bus.beg_FSM_CORDIC), 32'd0);
    chk({pfx, "_ack"},       32'(bus.ACK_FSM_CORDIC), 32'd0);
    chk({pfx, "_operation"}, 32'(bus.operation), 32'd0);
    chk({pfx, "_flag"},      32'(bus.shift_region_flag), 32'd0);
    chk({pfx, "_angle_red"}, bus.angle_red, 32'd0);
    chk({pfx, "_sign_neg"},  32'(bus.sign_neg), 32'd0);
  endtask

  // Issue a request and stop in the launch cycle, comparing against the scoreboard
  task automatic launch_txn(input vec_t v);
    int   n;
    vec_t e;
    bus.angle_in     = v.angle;
    bus.operation_in = v.op;
    bus.start        = 1'b1;
    sb.push_back(v);
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.beg_FSM_CORDIC && n < 8) begin
      tick();
      n++;
    end
    chk("launch_cycle", 32'(n + 1), 32'd3);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'(sb.size()));
    end else begin
      e = sb.pop_front();
      chk("flag",      32'(bus.shift_region_flag), 32'(e.flag));
      chk("angle_red", bus.angle_red, e.phi);
      chk("sign_neg",  32'(bus.sign_neg), 32'(e.sign));
      chk("operation", 32'(bus.operation), 32'(e.op));
    end
  endtask

  task automatic complete_from_wait();
    bus.ready_CORDIC = 1'b1;
    tick();
    chk("done_after_ready", 32'(bus.done), 32'd1);
    bus.ready_CORDIC = 1'b0;
    bus.ack_result   = 1'b1;
    #1;
    chk("ack_relay", 32'(bus.ACK_FSM_CORDIC), 32'd1);
    tick();
    bus.ack_result = 1'b0;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
  endtask

  task automatic finish_txn();
    tick();
    chk("beg_one_cycle", 32'(bus.beg_FSM_CORDIC), 32'd0);
    complete_from_wait();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int stuck;
    int beg_seen;
    checks = 0;
    errors = 0;
    vecs[0]  = '{32'h40000000, 1'b0, 2'b01, 32'h0DBC0957, 1'b1};
    vecs[1]  = '{32'hE0000000, 1'b1, 2'b00, 32'h16F0255E, 1'b0};
    vecs[2]  = '{32'h6487ED51, 1'b0, 2'b10, 32'h3243F6A9, 1'b1};
    vecs[3]  = '{32'hC90FDAA2, 1'b0, 2'b00, 32'h00000000, 1'b0};
    vecs[4]  = '{32'h3243F6A9, 1'b1, 2'b01, 32'h00000000, 1'b0};
    vecs[5]  = '{32'h96CBE3FA, 1'b1, 2'b11, 32'h3243F6A8, 1'b1};
    vecs[6]  = '{32'hFFFFFFFF, 1'b1, 2'b01, 32'h04AC2EB4, 1'b0};
    vecs[7]  = '{32'h80000000, 1'b0, 2'b10, 32'h16CBE3FA, 1'b1};
    vecs[8]  = '{32'hA0000000, 1'b1, 2'b11, 32'h290FDAA2, 1'b1};
    vecs[9]  = '{32'hC90FDAA1, 1'b0, 2'b11, 32'h00000001, 1'b0};
    vecs[10] = '{32'h00000000, 1'b0, 2'b00, 32'h00000000, 1'b0};

    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.angle_in     = '0;
    bus.operation_in = 1'b0;
    bus.ack_result   = 1'b0;
    bus.ready_CORDIC = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      launch_txn(vecs[i]);
      finish_txn();
    end

    // Long wait for the core, with a stray start and ack that must be ignored
    launch_txn(vecs[0]);
    tick();
    stuck = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        bus.start        = 1'b1;
        bus.angle_in     = 32'h80000000;
        bus.operation_in = 1'b1;
      end
      if (i == 3) bus.start = 1'b0;
      bus.ack_result = (i >= 5 && i < 8);
      tick();
      if (bus.done || bus.beg_FSM_CORDIC || !bus.busy || bus.ACK_FSM_CORDIC) stuck++;
    end
    bus.ack_result = 1'b0;
    chk("wait_hold_violations", 32'(stuck), 32'd0);
    chk("held_angle_red", bus.angle_red, 32'h0DBC0957);
    chk("held_flag", 32'(bus.shift_region_flag), 32'd1);
    chk("held_operation", 32'(bus.operation), 32'd0);
    chk("held_sign_neg", 32'(bus.sign_neg), 32'd1);
    complete_from_wait();
    tick();
    tick();
    chk("no_queued_start", 32'(bus.busy), 32'd0);

    // Reset asserted while in CLASS
    bus.angle_in     = 32'hA0000000;
    bus.operation_in = 1'b1;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_all_zero("mid_reset");
    beg_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.beg_FSM_CORDIC || bus.busy) beg_seen++;
    end
    chk("no_launch_after_reset", 32'(beg_seen), 32'd0);

    launch_txn(vecs[8]);
    finish_txn();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_angle_reducer.md
# cordic_angle_reducer

Front-end stage directly upstream of the CORDIC sine/cosine control FSM. It accepts an arbitrary angle in [0, 8) rad and reduces it modulo 2π. It maps the angle to a first-quadrant angle φ ∈ [0, π/2], encodes the original region on `shift_region_flag`, and computes the final-sign correction. It then launches the CORDIC core with a one-cycle `beg_FSM_CORDIC` pulse and relays the core's ready/ACK handshake to the requester.

## Interface
- `ANGLE_W`, 32: angle width. Fixed-point format is unsigned Q3.29. Only 32 is supported.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: request. Sampled only in IDLE.
- `angle_in` in 32: θ, unsigned Q3.29.
- `operation_in` in 1: 0 = cosine, 1 = sine.
- `ack_result` in 1: requester has taken the result.
- `ready_CORDIC` in 1: CORDIC core result ready.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: result available to the requester.
- `beg_FSM_CORDIC` out 1: one-cycle launch pulse to the core.
- `ACK_FSM_CORDIC` out 1: acknowledge to the core.
- `operation` out 1: registered copy of `operation_in`.
- `shift_region_flag` out 2: region code.
- `angle_red` out 32: φ in Q3.29.
- `sign_neg` out 1: the final result must be negated.

## Operation
States are IDLE, WRAP, CLASS, LAUNCH, WAIT, DONE.
- **IDLE**
  - On `start`: latch `angle_in` into a_r and `operation_in` into `operation`; go to WRAP.
  - Otherwise stay in IDLE.
- **WRAP**
  - If a_r ≥ TWO_PI: a_r ← a_r − TWO_PI. Otherwise a_r is unchanged.
  - One subtraction always suffices, because 8 − 2π < 2π.
  - Always go to CLASS.
- **CLASS**: register the region, φ and sign, then go to LAUNCH.
  - a_r < PI_HALF: flag 00, φ = a_r.
  - a_r < PI: flag 01, φ = a_r − PI_HALF.
  - a_r < THREE_PI_HALF: flag 10, φ = THREE_PI_HALF − a_r.
  - Otherwise: flag 11, φ = TWO_PI − a_r.
  - For cosine: `sign_neg` = flag ∈ {01, 10}.
  - For sine: `sign_neg` = flag ∈ {10, 11}.
- **LAUNCH**: `beg_FSM_CORDIC` = 1 for exactly this one cycle; go to WAIT.
- **WAIT**: when `ready_CORDIC` = 1, go to DONE. Otherwise stay.
- **DONE**
  - `done` = 1.
  - `ACK_FSM_CORDIC` = `ack_result` (combinational, gated by state == DONE).
  - On `ack_result`: go to IDLE.

Arithmetic rules:
- All subtractions are unsigned 32-bit. The ordering of the comparisons guarantees no underflow.
- φ ≤ PI_HALF in every region.
- Boundary cases:
  - θ = π/2 → flag 01, φ = 0.
  - θ = π → flag 10, φ = PI_HALF.
  - θ = 3π/2 → flag 11, φ = PI_HALF.
  - θ = TWO_PI → wraps to 0, flag 00.

## Timing
- Reset (`reset` = 0 at a clock edge): state = IDLE, a_r = 0, and every output = 0.
- Reset mid-operation: return to IDLE on that edge. No `beg_FSM_CORDIC` is issued afterwards, and no ACK is issued.
- Pipeline from `start` sampled at edge 0:
  - Edge 1: WRAP.
  - Edge 2: CLASS.
  - Edge 3: LAUNCH, so `beg_FSM_CORDIC` is high during cycle 3.
- `angle_red`, `shift_region_flag`, `sign_neg` and `operation` are registered at the edge leaving CLASS. They stay stable until the next return to IDLE, because the core samples them in its launch cycle.
- Ignored inputs:
  - `start` is ignored outside IDLE; no queueing.
  - `ready_CORDIC` is ignored outside WAIT.
  - `ack_result` is ignored outside DONE.
- If `ready_CORDIC` is already high on entry to WAIT, go to DONE on the next edge.
- DONE holds indefinitely until `ack_result`. `ack_result` and `ready_CORDIC` dropping in the same cycle still completes the transaction.
- Minimum request-to-request spacing: 6 cycles.

## Structure
- Package `cordic_angle_pkg` holds:
  - Q3.29 constants: PI_HALF = 0x3243F6A9, PI = 0x6487ED51, THREE_PI_HALF = 0x96CBE3FA, TWO_PI = 0xC90FDAA2.
  - The state enum.
  - The 2-bit region codes.
- One sub-module, `cordic_region_classify`: combinational comparator/subtractor producing flag, φ and `sign_neg` from a_r and `operation`. It is instantiated in CLASS.

## Test plan
- θ = 0x40000000 (2.0 rad), cos → flag 01, `angle_red` = 0x0DBC0957, `sign_neg` = 1, `beg_FSM_CORDIC` high in exactly cycle 3.
- θ = 0xE0000000 (7.0 rad), sin → wraps; flag 00, `angle_red` = 0x16F0255E, `sign_neg` = 0.
- θ = 0x6487ED51 (π), cos → flag 10, `angle_red` = 0x3243F6A9, `sign_neg` = 1. θ = 0xC90FDAA2 → flag 00, `angle_red` = 0.
- Handshake sequence:
  - Hold `ready_CORDIC` low for 20 cycles → stays in WAIT with `done` = 0.
  - Then raise `ready_CORDIC` → `done` = 1 next cycle.
  - Then `ack_result` = 1 → `ACK_FSM_CORDIC` = 1 in the same cycle, IDLE next cycle.
- `start` pulsed during WAIT → ignored; no second `beg_FSM_CORDIC`, outputs unchanged.
- `reset` = 0 in the CLASS cycle → all outputs 0 next cycle, no launch pulse; a fresh `start` then completes normally.
